// File: rtl/coder_seq_ctrl_pkg.sv
// coder_seq_ctrl_pkg
// Shared constants and types for the coder_seq_ctrl sequencer.
//   BLEN_06 : data bits carried by one coder_6_2 group
//   CW      : codeword width (one bit per TSV in a group)
//   MIN_EN  : fewest enabled TSVs the coder can still code with
//   state_e : sequencer FSM states
// Optional feature macro: CODER_SEQ_ERRCHK_EN (adds popcount8).
package coder_seq_ctrl_pkg;

  // Six active wires give 21 forbidden-transition-free codewords, so
  // a group carries four data bits.
  localparam int BLEN_06 = 4;
  localparam int CW      = 8;
  localparam int MIN_EN  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

`ifdef CODER_SEQ_ERRCHK_EN
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
`endif

endpackage

// File: rtl/coder_seq_ctrl_en_map_regs.sv
// en_map_regs
// Per-group TSV enable map: NGROUP x 8-bit register file with a single
// write port and a flat read-out of the whole map.
//   clock, rst_n : clock, asynchronous active-low reset (map -> 8'hFF)
//   we_i         : write strobe
//   addr_i       : group index; addresses >= NGROUP are ignored
//   data_i       : new enable mask, bit i enables TSV i
//   map_o        : full map, group g at [g*8 +: 8]
module en_map_regs #(
  parameter  int NGROUP = 4,
  localparam int AW     = $clog2(NGROUP)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [7:0]            data_i,
  output logic [NGROUP*8-1:0]   map_o
);

  logic [7:0] map_q [NGROUP];
  logic       addr_ok;

  // Only non-power-of-two NGROUP can see an out-of-range address.
  assign addr_ok = ({{(32-AW){1'b0}}, addr_i} < NGROUP);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NGROUP; i++) begin
        map_q[i] <= 8'hFF;
      end
    end else if (we_i && addr_ok) begin
      map_q[addr_i] <= data_i;
    end
  end

  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_flat
    assign map_o[gi*8 +: 8] = map_q[gi];
  end

endmodule

// File: rtl/coder_seq_ctrl.sv
// coder_seq_ctrl
// Time-multiplexes one coder_6_2 CAC encoder across NGROUP TSV groups.
// A word accepted on in_data is split into NGROUP slices which are fed,
// one per cycle, to the external coder together with that group's
// enable mask; the coder's registered codewords are gathered into
// out_code and offered on a valid/ready handshake.
//   clock, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/ready   : input word handshake
//   out_code/err/valid/ready : output word handshake
//   cfg_we/addr/data      : enable-map write port (any state)
//   cdr_datain/en_flag    : to coder, zero outside ENC
//   cdr_codeout           : from coder, one cycle after presentation
//   busy                  : high whenever not IDLE
// Optional feature macro: CODER_SEQ_ERRCHK_EN -- groups with fewer than
// MIN_EN enabled TSVs are flagged on out_err, get a zero mask and a
// zero codeword.
module coder_seq_ctrl
  import coder_seq_ctrl_pkg::*;
#(
  parameter  int NGROUP = 4,
  parameter  int DW     = BLEN_06,
  localparam int AW     = $clog2(NGROUP)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NGROUP*DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NGROUP*8-1:0]  out_code,
  output logic [NGROUP-1:0]    out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [7:0]           cfg_data,
  output logic [DW-1:0]        cdr_datain,
  output logic [7:0]           cdr_en_flag,
  input  logic [7:0]           cdr_codeout,
  output logic                 busy
);

  localparam logic [AW-1:0] GLAST = AW'(NGROUP - 1);

  state_e              state_q;
  logic [AW-1:0]       g_q;
  logic [AW-1:0]       g_nxt;
  logic [AW-1:0]       g_prv;
  logic                in_ready_q;
  logic                busy_q;
  logic                out_valid_q;
  logic [DW-1:0]       cdr_data_q;
  logic [7:0]          cdr_en_q;
  logic [7:0]          code_q  [NGROUP];
  logic [DW-1:0]       slice_q [NGROUP];
  logic [7:0]          snap_q  [NGROUP];
  logic [7:0]          map_arr [NGROUP];
  logic [NGROUP*8-1:0] map_flat;
  logic [NGROUP-1:0]   fault_now;
  logic [NGROUP-1:0]   fault_q;
  logic                accept;

  en_map_regs #(.NGROUP(NGROUP)) u_map (
    .clock  (clock),
    .rst_n  (rst_n),
    .we_i   (cfg_we),
    .addr_i (cfg_addr),
    .data_i (cfg_data),
    .map_o  (map_flat)
  );

  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_io
    assign map_arr[gi]         = map_flat[gi*8 +: 8];
    assign out_code[gi*8 +: 8] = code_q[gi];
  end

  assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign g_nxt  = g_q + 1'b1;
  // Capture lags presentation by one cycle: slot g is written while g+1
  // is on the coder inputs.
  assign g_prv  = g_q - 1'b1;

`ifdef CODER_SEQ_ERRCHK_EN
  always_comb begin
    fault_now = '0;
    for (int i = 0; i < NGROUP; i++) begin
      fault_now[i] = (popcount8(map_arr[i]) < 4'(MIN_EN));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
    end else if (accept) begin
      fault_q <= fault_now;
    end
  end
`else
  assign fault_now = '0;
  assign fault_q   = '0;
`endif

  // Word and map snapshot: pure data, only meaningful after an accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < NGROUP; i++) begin
        slice_q[i] <= in_data[i*DW +: DW];
        snap_q[i]  <= map_arr[i];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cdr_data_q  <= '0;
      cdr_en_q    <= '0;
      for (int i = 0; i < NGROUP; i++) begin
        code_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            // Group 0 goes to the coder straight from the live inputs so
            // it is presented in the first cycle after the accept.
            state_q    <= ST_ENC;
            g_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cdr_data_q <= in_data[DW-1:0];
            cdr_en_q   <= fault_now[0] ? 8'h00 : map_arr[0];
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_ENC: begin
          if (g_q != '0) begin
            code_q[g_prv] <= fault_q[g_prv] ? 8'h00 : cdr_codeout;
          end
          if (g_q == GLAST) begin
            state_q    <= ST_DRAIN;
            g_q        <= '0;
            cdr_data_q <= '0;
            cdr_en_q   <= '0;
          end else begin
            g_q        <= g_nxt;
            cdr_data_q <= slice_q[g_nxt];
            cdr_en_q   <= fault_q[g_nxt] ? 8'h00 : snap_q[g_nxt];
          end
        end
        ST_DRAIN: begin
          code_q[GLAST] <= fault_q[GLAST] ? 8'h00 : cdr_codeout;
          state_q       <= ST_OUT;
          out_valid_q   <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_err     = fault_q;
  assign cdr_datain  = cdr_data_q;
  assign cdr_en_flag = cdr_en_q;

endmodule
